// File: rtl/control_fsm_pkg.sv
// Shared encodings for the accumulator-machine controller: states, opcodes
// and the mux select codes consumed by the datapath.
package control_fsm_pkg;

    typedef enum logic [2:0] {
        S_INIT,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_LOAD  = 4'd4,
        OP_STORE = 4'd5,
        OP_LOADI = 4'd6,
        OP_BEQZ  = 4'd7,
        OP_JUMP  = 4'd8,
        OP_HALT  = 4'd9
    } opcode_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3
    } alu_op_t;

    typedef enum logic [2:0] {
        ACC_ALU = 3'd0,
        ACC_MEM = 3'd1,
        ACC_IMM = 3'd2
    } acc_src_t;

    typedef enum logic [2:0] {
        PC_INC = 3'd0,
        PC_IMM = 3'd1
    } pc_src_t;

    // Opcodes 0-3 are the ALU group; their low bits double as the ALUOp code.
    function automatic logic is_alu(input logic [3:0] op);
        return op[3:2] == 2'b00;
    endfunction

endpackage

// File: rtl/control_fsm_if.sv
// Controller <-> datapath bundle: instruction/status inputs and the
// per-cycle control strobes and mux selects.
interface control_fsm_if;
    logic [15:0] Instr;
    logic        MemReady;
    logic        AccZero;
    logic        IRWrite;
    logic        PCWrite;
    logic [2:0]  PCSrc;
    logic        MemRead;
    logic        MemWrite;
    logic        IorD;
    logic        AccWrite;
    logic [2:0]  AccSrc;
    logic [2:0]  ALUOp;
    logic        Halted;

    modport master (
        input  Instr, MemReady, AccZero,
        output IRWrite, PCWrite, PCSrc, MemRead, MemWrite, IorD,
               AccWrite, AccSrc, ALUOp, Halted
    );

    modport slave (
        output Instr, MemReady, AccZero,
        input  IRWrite, PCWrite, PCSrc, MemRead, MemWrite, IorD,
               AccWrite, AccSrc, ALUOp, Halted
    );
endinterface

// File: rtl/control_fsm_instr_counter.sv
// Retired-instruction counter: free-running wrap, async active-low clear.
module instr_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (en)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/control_fsm.sv
// Multicycle controller for a 16-bit accumulator machine: sequences fetch,
// decode, execute, memory and write-back, and counts retired instructions.
module control_fsm
    import control_fsm_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             Reset_n,
    control_fsm_if.master    bus,
    output logic [CNT_W-1:0] Retired
);

    state_t     state;
    logic       started;
    logic       retire;
    logic [3:0] op;

    assign op = bus.Instr[15:12];

    // INIT is held for one extra edge after reset release so the first
    // FETCH lands on the second rising edge.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= S_INIT;
            started <= 1'b0;
        end else begin
            started <= 1'b1;
            case (state)
                S_INIT:   if (started) state <= S_FETCH;
                S_FETCH:  if (bus.MemReady) state <= S_DECODE;
                S_DECODE: begin
                    if (is_alu(op) || op == OP_BEQZ || op == OP_JUMP)
                        state <= S_EXEC;
                    else if (op == OP_LOAD || op == OP_STORE)
                        state <= S_MEM;
                    else if (op == OP_LOADI)
                        state <= S_WB;
                    else if (op == OP_HALT)
                        state <= S_HALT;
                    else
                        state <= S_FETCH;
                end
                S_EXEC:   state <= is_alu(op) ? S_WB : S_FETCH;
                S_MEM:    if (bus.MemReady) state <= (op == OP_LOAD) ? S_WB : S_FETCH;
                S_WB:     state <= S_FETCH;
                S_HALT:   state <= S_HALT;
                default:  state <= S_INIT;
            endcase
        end
    end

    // Moore decode of state/opcode; only the handshake and branch flag
    // qualify strobes within a state.
    always_comb begin
        bus.IRWrite  = 1'b0;
        bus.PCWrite  = 1'b0;
        bus.PCSrc    = PC_INC;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.IorD     = 1'b0;
        bus.AccWrite = 1'b0;
        bus.AccSrc   = ACC_ALU;
        bus.ALUOp    = ALU_ADD;
        bus.Halted   = 1'b0;
        retire       = 1'b0;
        case (state)
            S_FETCH: begin
                bus.MemRead = 1'b1;
                if (bus.MemReady) begin
                    bus.IRWrite = 1'b1;
                    bus.PCWrite = 1'b1;
                end
            end
            S_DECODE: retire = (op >= 4'd10) || (op == OP_HALT);
            S_EXEC: begin
                if (is_alu(op)) begin
                    bus.ALUOp = op[2:0];
                end else begin
                    bus.PCSrc   = PC_IMM;
                    bus.PCWrite = (op == OP_JUMP) ? 1'b1 : bus.AccZero;
                    retire      = 1'b1;
                end
            end
            S_MEM: begin
                bus.IorD     = 1'b1;
                bus.MemRead  = (op == OP_LOAD);
                bus.MemWrite = (op == OP_STORE);
                retire       = bus.MemReady && (op == OP_STORE);
            end
            S_WB: begin
                bus.AccWrite = 1'b1;
                retire       = 1'b1;
                if (is_alu(op)) begin
                    bus.AccSrc = ACC_ALU;
                    bus.ALUOp  = op[2:0];
                end else if (op == OP_LOAD) begin
                    bus.AccSrc = ACC_MEM;
                end else begin
                    bus.AccSrc = ACC_IMM;
                end
            end
            S_HALT:  bus.Halted = 1'b1;
            default: ;
        endcase
    end

    instr_counter #(.CNT_W(CNT_W)) u_instr_counter (
        .clk   (CLK),
        .rst_n (Reset_n),
        .en    (retire),
        .count (Retired)
    );

endmodule
